// File: rtl/load_store_unit_if.sv
// Load/store unit bus: EX/MEM request, MEM/WB response and data memory.
// slave = LSU side, master = pipeline/memory side.
interface load_store_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              stall;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              misalign;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, req_write, req_size,
    input  req_signed, req_addr, req_wdata,
    input  mem_rdata,
    output stall, rsp_valid, rsp_rdata,
    output misalign, mem_addr, mem_wdata,
    output mem_read, mem_write
  );

  modport master (
    output req_valid, req_write, req_size,
    output req_signed, req_addr, req_wdata,
    output mem_rdata,
    input  stall, rsp_valid, rsp_rdata,
    input  misalign, mem_addr, mem_wdata,
    input  mem_read, mem_write
  );
endinterface

// File: rtl/load_store_unit.sv
// MEM-stage LSU: byte/half/word loads and stores over a word-wide memory.
// Ports: clk, rst_n (async low), bus (load_store_unit_if.slave).
// Option: LSU_MISALIGN_TRAP_EN enables misaligned-access trapping.
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input logic             clk,
  input logic             rst_n,
  load_store_unit_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    LD_WAIT,
    RMW_MERGE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [15:0]       r_wdata;
  logic              r_rsp_valid;
  logic [31:0]       r_rsp_rdata;
  logic              r_misalign;

  logic              w_mis;
  logic              w_cap;
  logic              w_rd;
  logic              w_wr;
  logic [ADDR_W-1:0] w_maddr;
  logic [31:0]       w_mwdata;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_ld;
  logic [31:0]       w_merge;

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_mis =
    (bus.req_size == 2'b01) ? bus.req_addr[0] :
    bus.req_size[1] ? (|bus.req_addr[1:0]) :
    1'b0;
`else
  assign w_mis = 1'b0;
`endif

  // Lane extract and extend from the captured request.
  always_comb begin
    w_byte = bus.mem_rdata[{r_addr[1:0], 3'b000} +: 8];
    w_half = r_addr[1] ? bus.mem_rdata[31:16]
                       : bus.mem_rdata[15:0];
    w_ld   = bus.mem_rdata;
    unique case (1'b1)
      (r_size == 2'b00):
        w_ld = {{24{r_signed & w_byte[7]}}, w_byte};
      (r_size == 2'b01):
        w_ld = {{16{r_signed & w_half[15]}}, w_half};
      default: w_ld = bus.mem_rdata;
    endcase
  end

  // Replace only the target lane of the old word.
  always_comb begin
    w_merge = bus.mem_rdata;
    if (r_size == 2'b00)
      w_merge[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
    else
      w_merge[{r_addr[1], 4'b0000} +: 16] = r_wdata;
  end

  always_comb begin
    w_next   = r_state;
    w_cap    = 1'b0;
    w_rd     = 1'b0;
    w_wr     = 1'b0;
    w_maddr  = {bus.req_addr[ADDR_W-1:2], 2'b00};
    w_mwdata = bus.req_wdata;
    unique case (r_state)
      IDLE: begin
        if (bus.req_valid && !w_mis) begin
          w_cap = 1'b1;
          if (bus.req_write && bus.req_size[1]) begin
            w_wr = 1'b1;
          end else begin
            w_rd   = 1'b1;
            w_next = bus.req_write ? RMW_MERGE : LD_WAIT;
          end
        end
      end
      LD_WAIT: begin
        w_maddr = {r_addr[ADDR_W-1:2], 2'b00};
        w_next  = IDLE;
      end
      RMW_MERGE: begin
        w_maddr  = {r_addr[ADDR_W-1:2], 2'b00};
        w_mwdata = w_merge;
        w_wr     = 1'b1;
        w_next   = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_size      <= 2'b00;
      r_signed    <= 1'b0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_misalign  <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_rsp_valid <= (r_state == LD_WAIT);
      r_misalign  <= (r_state == IDLE) &&
                     bus.req_valid && w_mis;
      if (r_state == LD_WAIT)
        r_rsp_rdata <= w_ld;
      if (w_cap) begin
        r_addr   <= bus.req_addr;
        r_size   <= bus.req_size;
        r_signed <= bus.req_signed;
        r_wdata  <= bus.req_wdata[15:0];
      end
    end
  end

  assign bus.stall     = (r_state != IDLE);
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.misalign  = r_misalign;
  assign bus.mem_addr  = w_maddr;
  assign bus.mem_wdata = w_mwdata;
  assign bus.mem_read  = w_rd;
  assign bus.mem_write = w_wr;
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit between the EX/MEM pipeline register and the word-wide data memory. It converts MIPS byte, halfword and word accesses (lb/lbu/lh/lhu/lw/sb/sh/sw) into full-word memory operations. Sub-word loads are lane-extracted and sign- or zero-extended; sub-word stores use a two-cycle read-modify-write. Load results go to the MEM/WB register, and a stall freezes upstream stages while a multi-cycle access is in flight.

## Interface
- ADDR_W, 32, width of req_addr and mem_addr
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  access request from EX/MEM
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word)
- req_signed  in  1  loads only: 1 sign-extends, 0 zero-extends
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified
- stall  out  1  upstream must hold; a request is not accepted while high
- rsp_valid  out  1  one-cycle load-result strobe to MEM/WB
- rsp_rdata  out  32  extended load result
- misalign  out  1  one-cycle misaligned-access strobe
- mem_addr  out  ADDR_W  word-aligned address, {req_addr[ADDR_W-1:2], 2'b00}
- mem_wdata  out  32  full word to memory
- mem_read, mem_write  out  1  memory strobes
- mem_rdata  in  32  memory read data, valid the cycle after mem_read (synchronous read)

## Operation
- States:
  - IDLE: requests are accepted here only.
  - LD_WAIT: wait for load data.
  - RMW_MERGE: merge and write back a sub-word store.
- stall is high exactly when state != IDLE, and is decoded from the state register.
- On acceptance, the request (address, size, signed, write data) is registered internally. Upstream may change its inputs afterwards.
- Load, in IDLE with req_valid:
  - mem_read is driven combinationally that cycle with the aligned address.
  - Next state is LD_WAIT.
  - In LD_WAIT, the byte/halfword lane is taken from mem_rdata using the captured address, extended, and registered into rsp_rdata with rsp_valid set. Then back to IDLE.
- Word store, in IDLE: mem_write is driven the same cycle with mem_wdata = req_wdata. Stays in IDLE, no stall.
- Sub-word store, in IDLE:
  - mem_read is driven on the aligned address; go to RMW_MERGE.
  - In RMW_MERGE, only the target lane of mem_rdata is replaced with req_wdata[7:0] (byte) or req_wdata[15:0] (halfword).
  - mem_write is asserted with the merged word, then back to IDLE.
- Lane mapping is little-endian: byte k = word[8k+7:8k], with k = addr[1:0]. Halfword lane = addr[1] (bits [15:0] or [31:16]).
- Extension rules:
  - lb replicates bit 7; lh replicates bit 15.
  - lbu/lhu zero-fill.
  - lw ignores req_signed.
- mem_read and mem_write are never asserted in the same cycle. Both are 0 whenever no access is in progress.
- rsp_rdata holds its value between strobes.

## Timing
- Request sampled at cycle T:
  - Load: mem_read in T, mem_rdata in T+1, rsp_valid high in T+2. stall high in T+1.
  - Word store: memory write at the end of T, zero stall.
  - Sub-word store: read in T, write at the end of T+1, stall high in T+1.
- Back-to-back: after a load or sub-word store at T, the next request is accepted at T+2.
  - A load at T+2 observes an RMW write completed at the end of T+1.
- Reset (rst_n low, asynchronous):
  - state IDLE, stall 0, rsp_valid 0, rsp_rdata 0, misalign 0, mem_read/mem_write 0.
  - Reset during LD_WAIT or RMW_MERGE abandons the access: no rsp_valid and no memory write.
- req_valid low in IDLE: no memory strobes, no state change.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - A misaligned access (halfword with addr[0]=1, or word with addr[1:0]!=0) issues no memory strobe and stays in IDLE.
  - misalign pulses high in T+1; no rsp_valid.
- LSU_MISALIGN_TRAP_EN undefined:
  - misalign is tied to 0.
  - Low address bits below the access size are ignored (halfword uses addr[1]; word uses lane 0). The access proceeds normally.

## Test plan
- Reset: assert rst_n=0 mid-RMW (state RMW_MERGE) -> no mem_write; after release stall=0, rsp_valid=0, rsp_rdata=0.
- Word store then load: sw 0xDEADBEEF @0x8, then lw @0x8 -> rsp_valid at T+2, rsp_rdata=0xDEADBEEF; stall high one cycle.
- Byte loads of word 0x80FF7F01 @0x4:
  - lb @0x7 -> 0xFFFFFF80
  - lbu @0x7 -> 0x00000080
  - lb @0x5 -> 0x0000007F
  - lh @0x6 -> 0xFFFF80FF
  - lhu @0x4 -> 0x00007F01
- Sub-word store: memory @0xC = 0x11223344, sb 0xAB @0xD -> merged write 0x1122AB44; then sh 0xCAFE @0xE -> 0xCAFEAB44. Each stalls exactly one cycle.
- Back-to-back: req_valid held with load @0x0 then load @0x4 -> accepts at T and T+2, rsp_valid at T+2 and T+4, mem_read never in T+1.
- Misalign: lw @0x6.
  - With LSU_MISALIGN_TRAP_EN: misalign=1 at T+1, no mem_read, no rsp_valid.
  - Without: a word read of @0x4 is returned.
